alu_resp_collector: RTL and testbench
=====================================

// Module: alu_resp_collector
// PURPOSE
// - Response-side end of the ALU channel: captures ALU outputs when the ALU result is valid and extracts the result slice for the issued opcode.
// - Buffers captured responses in a FIFO and returns them to a consumer over a valid/ready handshake.
// - Keeps saturating compare-flag statistics, plus sticky overflow and protocol-error flags.
// - Sits between the ALU datapath and the result consumer (checker, scoreboard or CPU-side reader).
// PARAMETERS
// - WIDTH  default 4  bits per ALU slice.
// - n_alu  default 4  number of chained ALU slices; DW = WIDTH*n_alu.
// - DEPTH  default 8  FIFO entries; power of two, >= 2.
// - CNT_W  default 16 width of each statistics counter.
// PORTS
// - clk           in   1        single clock; all logic on posedge.
// - arst          in   1        reset: synchronous, active-high; sampled on posedge clk.
// - alu_valid     in   1        ALU outputs are valid this cycle (one capture per cycle).
// - select        in   3        opcode the result belongs to.
// - out           in   DW*8     all 8 op results, op k at out[k*DW +: DW].
// - carry_out     in   1        carry of the selected op.
// - a_greater     in   1        compare flag.
// - a_equal       in   1        compare flag.
// - a_less        in   1        compare flag.
// - rsp_valid     out  1        head entry available.
// - rsp_ready     in   1        consumer accepts head entry.
// - rsp_sel       out  3        opcode of the head entry.
// - rsp_result    out  DW       result slice of the head entry.
// - rsp_carry     out  1        carry of the head entry.
// - rsp_flags     out  3        {a_greater,a_equal,a_less} of the head entry.
// - level         out  $clog2(DEPTH)+1  current occupancy.
// - overflow      out  1        sticky: a capture was dropped.
// - proto_err     out  1        sticky: flags were not one-hot on a capture.
// - cnt_gt        out  CNT_W    saturating count of captures with a_greater=1.
// - cnt_eq        out  CNT_W    saturating count of captures with a_equal=1.
// - cnt_lt        out  CNT_W    saturating count of captures with a_less=1.
// BEHAVIOUR
// - Reset (arst=1 at posedge): FIFO emptied (rd_ptr=wr_ptr=0); outputs go to rsp_valid=0, level=0, overflow=0, proto_err=0, cnt_*=0.
// - rsp_* data fields are X-free 0 after reset.
// - Reset overrides a simultaneous push or pop. Entries in flight when reset asserts are discarded.
// - Capture: on a cycle with alu_valid=1 and no drop, push {select, out[select*DW +: DW], carry_out, flags}.
// - Latency: capture in cycle N gives rsp_valid=1 from cycle N+1. No combinational bypass.
// - Pop occurs when rsp_valid & rsp_ready. The next entry (if any) is presented in the following cycle.
// - rsp_* fields are stable while rsp_valid=1 and rsp_ready=0.
// - Full and no pop in the same cycle: the capture is dropped and overflow is set; FIFO contents are unchanged.
// - Full and pop in the same cycle: the capture is accepted and level stays at DEPTH.
// - Empty: pop is impossible (rsp_valid=0). A capture sets level to 1.
// - Simultaneous push and pop when not empty: level unchanged.
// - Pointers: $clog2(DEPTH)+1 bits; wrap modulo 2*DEPTH. full = MSBs differ and the rest are equal.
// - Statistics update on every alu_valid cycle, including dropped captures. Each counter saturates at all-ones and does not wrap.
// - proto_err is set when alu_valid=1 and $countones(flags)!=1. The entry is still pushed with the flags as received.
// - Sticky flags clear only on reset.
// STRUCTURE
// - Package alu_pkg holds:
//   - alu_op_e: 3-bit opcode enum.
//   - alu_resp_t: packed struct {sel, result[DW], carry, flags[3]}.
//   - localparam N_OPS=8.
//   - flag bit index constants FLAG_GT=2, FLAG_EQ=1, FLAG_LT=0.
// - Sub-module alu_resp_fifo:
//   - parameterised on the alu_resp_t width and DEPTH.
//   - ports push, push_data, pop, head, level, full, empty.
//   - its registered head drives rsp_*.
// - Top-level alu_resp_collector holds the slice mux, drop/overflow logic, protocol check and counters.
// TESTING
// - Reset/basic: arst=1 for 2 cycles, then one capture with select=3, out slice 3=16'hBEEF, carry_out=1, flags=3'b100.
//   Required: rsp_valid=1 next cycle, rsp_sel=3, rsp_result=16'hBEEF, rsp_carry=1, rsp_flags=3'b100, cnt_gt=1.
// - Backpressure/fill: rsp_ready=0 with 8 captures tagged 0..7.
//   Then a 9th capture: overflow=1, level=8.
//   Then rsp_ready=1: entries drain in order 0..7, rsp_result holds each value until its pop.
// - Full push+pop: with level=8, alu_valid=1 and rsp_ready=1 in the same cycle.
//   Required: level stays 8, overflow stays 0, and the new entry is the last out after 8 pops.
// - Protocol error: capture with flags=3'b011. Required: proto_err=1, entry pushed with flags 3'b011, cnt_eq and cnt_lt both increment.
// - Saturation: force cnt_gt to 16'hFFFE (or CNT_W=2 build), then 3 captures with a_greater=1. Required: cnt_gt holds at all-ones.
// - Reset mid-operation: level=5 and rsp_valid=1, then arst=1 in the same cycle as a capture.
//   Required: next cycle level=0, rsp_valid=0, overflow=0, proto_err=0, cnt_*=0, and the capture is discarded.

Source files
------------

// File: rtl/alu_resp_collector_pkg.sv
// Shared types and constants for the ALU response collector.
package alu_pkg;

  localparam int unsigned N_OPS   = 8;
  localparam int unsigned FLAG_GT = 2;
  localparam int unsigned FLAG_EQ = 1;
  localparam int unsigned FLAG_LT = 0;

  // Default datapath geometry (WIDTH=4, n_alu=4).
  localparam int unsigned DEF_DW  = 16;

  typedef enum logic [2:0] {
    ALU_OP0 = 3'd0,
    ALU_OP1 = 3'd1,
    ALU_OP2 = 3'd2,
    ALU_OP3 = 3'd3,
    ALU_OP4 = 3'd4,
    ALU_OP5 = 3'd5,
    ALU_OP6 = 3'd6,
    ALU_OP7 = 3'd7
  } alu_op_e;

  // Entry layout for the default geometry; the collector packs the same
  // field order {sel, result, carry, flags} for any DW.
  typedef struct packed {
    alu_op_e            sel;
    logic [DEF_DW-1:0]  result;
    logic               carry;
    logic [2:0]         flags;
  } alu_resp_t;

  // Exactly one of {gt, eq, lt} must be set on a valid compare.
  function automatic logic flags_onehot(input logic [2:0] f);
    return ($countones(f) == 1);
  endfunction

endpackage

// File: rtl/alu_resp_collector_if.sv
// Response channel from the collector to its consumer.
interface alu_resp_collector_if #(
  parameter int unsigned DW = 16
);
  logic          rsp_valid;
  logic          rsp_ready;
  logic [2:0]    rsp_sel;
  logic [DW-1:0] rsp_result;
  logic          rsp_carry;
  logic [2:0]    rsp_flags;

  modport master (
    output rsp_valid, rsp_sel, rsp_result, rsp_carry, rsp_flags,
    input  rsp_ready
  );

  modport slave (
    input  rsp_valid, rsp_sel, rsp_result, rsp_carry, rsp_flags,
    output rsp_ready
  );
endinterface

// File: rtl/alu_resp_collector_fifo.sv
// Register-array FIFO with wrap-bit pointers; head is read straight from
// the storage registers, so it is registered and zero after reset.
module alu_resp_fifo #(
  parameter int unsigned W     = 23,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_pop;
  logic         w_push;

  // Status derived from pointers; full when wrap bits differ and indices match.
  always_comb begin
    empty  = (r_wr_ptr == r_rd_ptr);
    full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
             (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    level  = r_wr_ptr - r_rd_ptr;
    head   = r_mem[r_rd_ptr[AW-1:0]];
    w_pop  = pop & ~empty;
    w_push = push & (~full | w_pop);
  end

  // Storage and pointer update; reset clears storage so head is X-free.
  always_ff @(posedge clk) begin
    if (arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_resp_collector.sv
// Captures the selected ALU result slice, buffers it and keeps statistics.
module alu_resp_collector
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned n_alu = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                            clk,
  input  logic                            arst,
  input  logic                            alu_valid,
  input  logic [2:0]                      select,
  input  logic [WIDTH*n_alu*N_OPS-1:0]    out,
  input  logic                            carry_out,
  input  logic                            a_greater,
  input  logic                            a_equal,
  input  logic                            a_less,
  alu_resp_collector_if.master            rsp,
  output logic [$clog2(DEPTH):0]          level,
  output logic                            overflow,
  output logic                            proto_err,
  output logic [CNT_W-1:0]                cnt_gt,
  output logic [CNT_W-1:0]                cnt_eq,
  output logic [CNT_W-1:0]                cnt_lt
);
  localparam int unsigned DW = WIDTH * n_alu;
  localparam int unsigned RW = 3 + DW + 1 + 3;

  alu_op_e       w_sel;
  logic [DW-1:0] w_result;
  logic [2:0]    w_flags;
  logic [RW-1:0] w_push_data;
  logic [RW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  logic          r_overflow;
  logic          r_proto_err;
  logic [CNT_W-1:0] r_cnt_gt;
  logic [CNT_W-1:0] r_cnt_eq;
  logic [CNT_W-1:0] r_cnt_lt;

  // Slice mux, flag packing and push/drop decision.
  always_comb begin
    w_sel            = alu_op_e'(select);
    w_result         = out[select*DW +: DW];
    w_flags          = '0;
    w_flags[FLAG_GT] = a_greater;
    w_flags[FLAG_EQ] = a_equal;
    w_flags[FLAG_LT] = a_less;
    w_push_data      = {w_sel, w_result, carry_out, w_flags};
    w_pop            = ~w_empty & rsp.rsp_ready;
    w_drop           = alu_valid & w_full & ~w_pop;
    w_push           = alu_valid & ~w_drop;
  end

  alu_resp_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst      (arst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .level     (level),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Response channel is the FIFO head unpacked.
  always_comb begin
    rsp.rsp_valid = ~w_empty;
    {rsp.rsp_sel, rsp.rsp_result, rsp.rsp_carry, rsp.rsp_flags} = w_head;
  end

  // Sticky overflow/protocol flags and saturating compare statistics.
  always_ff @(posedge clk) begin
    if (arst) begin
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
      r_cnt_gt    <= '0;
      r_cnt_eq    <= '0;
      r_cnt_lt    <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (alu_valid && !flags_onehot(w_flags)) begin
        r_proto_err <= 1'b1;
      end
      if (alu_valid && a_greater && (r_cnt_gt != '1)) begin
        r_cnt_gt <= r_cnt_gt + 1'b1;
      end
      if (alu_valid && a_equal && (r_cnt_eq != '1)) begin
        r_cnt_eq <= r_cnt_eq + 1'b1;
      end
      if (alu_valid && a_less && (r_cnt_lt != '1)) begin
        r_cnt_lt <= r_cnt_lt + 1'b1;
      end
    end
  end

  // Register outputs.
  always_comb begin
    overflow  = r_overflow;
    proto_err = r_proto_err;
    cnt_gt    = r_cnt_gt;
    cnt_eq    = r_cnt_eq;
    cnt_lt    = r_cnt_lt;
  end

endmodule

// File: tb/tb_alu_resp_collector.sv
// Directed, table-driven bench for alu_resp_collector.
module tb_alu_resp_collector;
  import alu_pkg::*;

  logic         clk;
  logic         arst;
  logic         alu_valid;
  logic [2:0]   select;
  logic [127:0] out;
  logic         carry_out;
  logic         a_greater;
  logic         a_equal;
  logic         a_less;
  logic [3:0]   level;
  logic         overflow;
  logic         proto_err;
  logic [15:0]  cnt_gt;
  logic [15:0]  cnt_eq;
  logic [15:0]  cnt_lt;

  logic [3:0]   s_level;
  logic         s_overflow;
  logic         s_proto_err;
  logic [1:0]   s_cnt_gt;
  logic [1:0]   s_cnt_eq;
  logic [1:0]   s_cnt_lt;

  int checks;
  int errors;
  int exp_gt;
  int exp_eq;
  int exp_lt;

  alu_resp_collector_if #(.DW(16)) rif ();
  alu_resp_collector_if #(.DW(16)) sif ();

  alu_resp_collector dut (
    .clk       (clk),
    .arst      (arst),
    .alu_valid (alu_valid),
    .select    (select),
    .out       (out),
    .carry_out (carry_out),
    .a_greater (a_greater),
    .a_equal   (a_equal),
    .a_less    (a_less),
    .rsp       (rif),
    .level     (level),
    .overflow  (overflow),
    .proto_err (proto_err),
    .cnt_gt    (cnt_gt),
    .cnt_eq    (cnt_eq),
    .cnt_lt    (cnt_lt)
  );

  // Narrow-counter build used for the saturation case.
  alu_resp_collector #(.CNT_W(2)) u_sat (
    .clk       (clk),
    .arst      (arst),
    .alu_valid (alu_valid),
    .select    (select),
    .out       (out),
    .carry_out (carry_out),
    .a_greater (a_greater),
    .a_equal   (a_equal),
    .a_less    (a_less),
    .rsp       (sif),
    .level     (s_level),
    .overflow  (s_overflow),
    .proto_err (s_proto_err),
    .cnt_gt    (s_cnt_gt),
    .cnt_eq    (s_cnt_eq),
    .cnt_lt    (s_cnt_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    alu_resp_t r;
  } vec_t;

  vec_t fill_tab [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Advance one clock; expected statistics follow the inputs seen at the edge.
  task automatic step();
    if (arst) begin
      exp_gt = 0; exp_eq = 0; exp_lt = 0;
    end else if (alu_valid) begin
      if (a_greater) exp_gt++;
      if (a_equal)   exp_eq++;
      if (a_less)    exp_lt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input alu_resp_t r);
    alu_valid = 1'b1;
    select    = r.sel;
    for (int k = 0; k < 8; k++) out[k*16 +: 16] = 16'hC0C0 ^ 16'(k);
    out[r.sel*16 +: 16] = r.result;
    carry_out = r.carry;
    {a_greater, a_equal, a_less} = r.flags;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    {a_greater, a_equal, a_less} = 3'b000;
  endtask

  task automatic chk_head(input string tag, input alu_resp_t e);
    chk({tag, "_valid"},  32'(rif.rsp_valid),  32'd1);
    chk({tag, "_sel"},    32'(rif.rsp_sel),    32'(e.sel));
    chk({tag, "_result"}, 32'(rif.rsp_result), 32'(e.result));
    chk({tag, "_carry"},  32'(rif.rsp_carry),  32'(e.carry));
    chk({tag, "_flags"},  32'(rif.rsp_flags),  32'(e.flags));
  endtask

  task automatic do_reset();
    idle();
    rif.rsp_ready = 1'b0;
    arst = 1'b1;
    step();
    step();
    arst = 1'b0;
  endtask

  task automatic fill8();
    rif.rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(fill_tab[i].r);
      step();
      chk("fill_level", 32'(level), 32'(i + 1));
      chk_head("fill_head", fill_tab[0].r);
    end
    idle();
  endtask

  alu_resp_t e;

  initial begin
    checks = 0; errors = 0;
    exp_gt = 0; exp_eq = 0; exp_lt = 0;
    arst = 1'b1; alu_valid = 1'b0; select = '0; out = '0; carry_out = 1'b0;
    a_greater = 1'b0; a_equal = 1'b0; a_less = 1'b0;
    rif.rsp_ready = 1'b0;
    sif.rsp_ready = 1'b1;

    fill_tab[0].r = '{sel: ALU_OP0, result: 16'h1111, carry: 1'b0, flags: 3'b100};
    fill_tab[1].r = '{sel: ALU_OP1, result: 16'h2222, carry: 1'b1, flags: 3'b010};
    fill_tab[2].r = '{sel: ALU_OP2, result: 16'h3333, carry: 1'b0, flags: 3'b001};
    fill_tab[3].r = '{sel: ALU_OP3, result: 16'h4444, carry: 1'b1, flags: 3'b100};
    fill_tab[4].r = '{sel: ALU_OP4, result: 16'h5555, carry: 1'b0, flags: 3'b010};
    fill_tab[5].r = '{sel: ALU_OP5, result: 16'h6666, carry: 1'b1, flags: 3'b001};
    fill_tab[6].r = '{sel: ALU_OP6, result: 16'h7777, carry: 1'b0, flags: 3'b100};
    fill_tab[7].r = '{sel: ALU_OP7, result: 16'h8888, carry: 1'b1, flags: 3'b010};

    // Reset state
    do_reset();
    chk("rst_valid",  32'(rif.rsp_valid),  32'd0);
    chk("rst_level",  32'(level),          32'd0);
    chk("rst_ovf",    32'(overflow),       32'd0);
    chk("rst_proto",  32'(proto_err),      32'd0);
    chk("rst_gt",     32'(cnt_gt),         32'd0);
    chk("rst_eq",     32'(cnt_eq),         32'd0);
    chk("rst_lt",     32'(cnt_lt),         32'd0);
    chk("rst_sel",    32'(rif.rsp_sel),    32'd0);
    chk("rst_result", 32'(rif.rsp_result), 32'd0);
    chk("rst_flags",  32'(rif.rsp_flags),  32'd0);

    // Basic capture with one-cycle latency and no bypass
    e = '{sel: ALU_OP3, result: 16'hBEEF, carry: 1'b1, flags: 3'b100};
    drive(e);
    #1;
    chk("no_bypass", 32'(rif.rsp_valid), 32'd0);
    step();
    idle();
    chk_head("basic", e);
    chk("basic_gt",    32'(cnt_gt), 32'd1);
    chk("basic_level", 32'(level),  32'd1);
    rif.rsp_ready = 1'b1;
    step();
    chk("basic_popped_valid", 32'(rif.rsp_valid), 32'd0);
    chk("basic_popped_level", 32'(level),         32'd0);

    // Backpressure fill, dropped 9th capture, ordered drain with hold
    fill8();
    e = '{sel: ALU_OP5, result: 16'hDEAD, carry: 1'b0, flags: 3'b001};
    drive(e);
    step();
    idle();
    chk("ovf_flag",  32'(overflow), 32'd1);
    chk("ovf_level", 32'(level),    32'd8);
    chk("ovf_gt",    32'(cnt_gt),   32'(exp_gt));
    chk("ovf_eq",    32'(cnt_eq),   32'(exp_eq));
    chk("ovf_lt",    32'(cnt_lt),   32'(exp_lt));
    chk("ovf_lt_abs", 32'(cnt_lt),  32'd3);
    for (int i = 0; i < 8; i++) begin
      chk_head("drain", fill_tab[i].r);
      rif.rsp_ready = 1'b0;
      step();
      chk_head("drain_hold", fill_tab[i].r);
      rif.rsp_ready = 1'b1;
      step();
    end
    chk("drain_empty", 32'(rif.rsp_valid), 32'd0);
    chk("drain_ovf_sticky", 32'(overflow), 32'd1);

    // Full with simultaneous push and pop
    do_reset();
    fill8();
    e = '{sel: ALU_OP6, result: 16'h5A5A, carry: 1'b1, flags: 3'b010};
    drive(e);
    rif.rsp_ready = 1'b1;
    step();
    idle();
    rif.rsp_ready = 1'b0;
    chk("fpp_level", 32'(level),    32'd8);
    chk("fpp_ovf",   32'(overflow), 32'd0);
    rif.rsp_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk_head("fpp_drain", fill_tab[i].r);
      step();
    end
    chk_head("fpp_last", e);
    step();
    chk("fpp_empty", 32'(level), 32'd0);

    // Protocol error: non-one-hot flags still pushed and counted
    e = '{sel: ALU_OP2, result: 16'h1234, carry: 1'b0, flags: 3'b011};
    drive(e);
    rif.rsp_ready = 1'b0;
    step();
    idle();
    chk("proto_flag", 32'(proto_err), 32'd1);
    chk_head("proto", e);
    chk("proto_eq", 32'(cnt_eq), 32'(exp_eq));
    chk("proto_lt", 32'(cnt_lt), 32'(exp_lt));
    rif.rsp_ready = 1'b1;
    step();

    // Saturation on the 2-bit counter build
    do_reset();
    rif.rsp_ready = 1'b1;
    e = '{sel: ALU_OP1, result: 16'h0F0F, carry: 1'b0, flags: 3'b100};
    for (int i = 0; i < 5; i++) begin
      drive(e);
      step();
      chk("sat_gt", 32'(s_cnt_gt), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    idle();
    chk("sat_main_gt", 32'(cnt_gt), 32'd5);

    // Reset in the same cycle as a capture, with entries in flight
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(fill_tab[i].r);
      if (i == 4) {a_greater, a_equal, a_less} = 3'b000;
      step();
    end
    idle();
    chk("mid_level", 32'(level),          32'd5);
    chk("mid_valid", 32'(rif.rsp_valid),  32'd1);
    chk("mid_proto", 32'(proto_err),      32'd1);
    drive(fill_tab[7].r);
    arst = 1'b1;
    step();
    arst = 1'b0;
    idle();
    chk("mrst_level", 32'(level),         32'd0);
    chk("mrst_valid", 32'(rif.rsp_valid), 32'd0);
    chk("mrst_ovf",   32'(overflow),      32'd0);
    chk("mrst_proto", 32'(proto_err),     32'd0);
    chk("mrst_gt",    32'(cnt_gt),        32'd0);
    chk("mrst_eq",    32'(cnt_eq),        32'd0);
    chk("mrst_lt",    32'(cnt_lt),        32'd0);
    step();
    chk("mrst_discard", 32'(level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
